argmax_scheduler: RTL and testbench

Streams NUM_CLASSES signed classifier scores one per beat, packs them into 4-lane groups and issues each group to a 4-input argmax compare stage. It folds every group winner into a running best and returns the final (class index, score) pair on a valid/ready output. It sits between the final dense layer and the result/UART reporting logic, so the 4-lane comparator can serve classifiers of any width up to 32.

---
 rtl/argmax_pkg.sv | 10 +
 rtl/softmax_core.sv | 39 +++
 rtl/argmax_scheduler.sv | 98 +++++++++
 tb/tb_argmax_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/argmax_pkg.sv
// argmax_pkg: shared types and constants for the argmax scheduler
package argmax_pkg;
  typedef enum logic [1:0] {COLLECT, DRAIN, HOLD} state_t;
  localparam int LANES = 4;
  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] PAD_IDX = 5'd31;
  function automatic logic [31:0] most_neg(input int dw);
    return 32'd1 << (dw - 1);
  endfunction
endpackage

// File: rtl/softmax_core.sv
// softmax_core: registered N-input signed argmax, ties resolve to the lowest lane
module softmax_core import argmax_pkg::*; #(
  parameter int NUM_INPUT  = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            i_valid,
  input  logic [NUM_INPUT*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_INPUT*IDX_W-1:0]      i_idx,
  output logic                            o_valid,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic [IDX_W-1:0]                o_idx
);
  logic [DATA_WIDTH-1:0] w_d;
  logic [IDX_W-1:0]      w_i;
  always_comb begin
    w_d = i_data[DATA_WIDTH-1:0];
    w_i = i_idx[IDX_W-1:0];
    for (int k = 1; k < NUM_INPUT; k++)
      if ($signed(i_data[k*DATA_WIDTH+:DATA_WIDTH]) > $signed(w_d)) begin
        w_d = i_data[k*DATA_WIDTH+:DATA_WIDTH];
        w_i = i_idx[k*IDX_W+:IDX_W];
      end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_idx   <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_data <= w_d;
        o_idx  <= w_i;
      end
    end
  end
endmodule

// File: rtl/argmax_scheduler.sv
// argmax_scheduler: packs streamed scores into 4-lane groups, folds group winners
// into a running best and returns the frame's (index, score) on valid/ready
module argmax_scheduler import argmax_pkg::*; #(
  parameter int NUM_CLASSES = 24,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [IDX_W-1:0]      m_index,
  output logic [DATA_WIDTH-1:0] m_data
);
  localparam logic [DATA_WIDTH-1:0] NEG  = DATA_WIDTH'(most_neg(DATA_WIDTH));
  localparam logic [IDX_W-1:0]      LAST = IDX_W'(NUM_CLASSES - 1);
  state_t                  r_state;
  logic [IDX_W-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   r_lane_d [LANES];
  logic [IDX_W-1:0]        r_lane_i [LANES];
  logic                    r_issue, r_first;
  logic [DATA_WIDTH-1:0]   r_best_d;
  logic [IDX_W-1:0]        r_best_i;
  logic                    w_acc, w_last, w_cv;
  logic [1:0]              w_slot;
  logic [DATA_WIDTH-1:0]   w_cd;
  logic [IDX_W-1:0]        w_ci;
  logic [LANES*DATA_WIDTH-1:0] w_lane_d;
  logic [LANES*IDX_W-1:0]      w_lane_i;
  assign s_ready = r_state == COLLECT;
  assign m_valid = r_state == HOLD;
  assign m_index = r_best_i;
  assign m_data  = r_best_d;
  assign w_acc   = s_valid && s_ready && !clear;
  assign w_last  = r_cnt == LAST;
  assign w_slot  = r_cnt[1:0];
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lane_d[g*DATA_WIDTH+:DATA_WIDTH] = r_lane_d[g];
    assign w_lane_i[g*IDX_W+:IDX_W]           = r_lane_i[g];
  end
  softmax_core #(.NUM_INPUT(LANES), .DATA_WIDTH(DATA_WIDTH)) u_core (
    .clk     (clk),
    .resetn  (resetn),
    .i_valid (r_issue && !clear),
    .i_data  (w_lane_d),
    .i_idx   (w_lane_i),
    .o_valid (w_cv),
    .o_data  (w_cd),
    .o_idx   (w_ci)
  );
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      r_state  <= COLLECT;
      r_cnt    <= '0;
      r_issue  <= 1'b0;
      r_first  <= 1'b1;
      r_best_d <= '0;
      r_best_i <= '0;
      for (int k = 0; k < LANES; k++) begin
        r_lane_d[k] <= NEG;
        r_lane_i[k] <= PAD_IDX;
      end
    end else begin
      r_issue <= w_acc && (w_slot == 2'd3 || w_last);
      // starting a group pads the upper lanes so a short final group sees padding
      if (w_acc) begin
        r_cnt <= r_cnt + 1'b1;
        for (int k = 0; k < LANES; k++)
          if (2'(k) == w_slot) begin
            r_lane_d[k] <= s_data;
            r_lane_i[k] <= r_cnt;
          end else if (w_slot == 2'd0) begin
            r_lane_d[k] <= NEG;
            r_lane_i[k] <= PAD_IDX;
          end
      end
      if (w_cv && (r_first || $signed(w_cd) > $signed(r_best_d))) begin
        r_best_d <= w_cd;
        r_best_i <= w_ci;
      end
      if (w_cv) r_first <= 1'b0;
      if (r_state == COLLECT && w_acc && w_last) r_state <= DRAIN;
      if (r_state == DRAIN && w_cv && !r_issue) r_state <= HOLD;
      if (r_state == HOLD && m_ready) begin
        r_state <= COLLECT;
        r_cnt   <= '0;
        r_first <= 1'b1;
        for (int k = 0; k < LANES; k++) begin
          r_lane_d[k] <= NEG;
          r_lane_i[k] <= PAD_IDX;
        end
      end
    end
  end
endmodule

// File: tb/tb_argmax_scheduler.sv
// tb_argmax_scheduler: directed frames with a scoreboard queue per DUT instance
module tb_argmax_scheduler;
  typedef struct packed {logic [4:0] i; logic [15:0] d;} res_t;
  typedef logic [15:0] vec_t [32];
  logic clk = 0, resetn = 0, clear = 0;
  logic a_valid = 0, a_ready, a_mv, a_mr = 1;
  logic [15:0] a_data = 0, a_md;
  logic [4:0] a_mi;
  logic b_valid = 0, b_ready, b_mv, b_mr = 1;
  logic [15:0] b_data = 0, b_md;
  logic [4:0] b_mi;
  int cyc = 0, n_tests = 0, n_fail = 0;
  res_t qa[$], qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  argmax_scheduler #(.NUM_CLASSES(24), .DATA_WIDTH(16)) u_a (
    .clk(clk), .resetn(resetn), .clear(clear), .s_valid(a_valid), .s_ready(a_ready),
    .s_data(a_data), .m_valid(a_mv), .m_ready(a_mr), .m_index(a_mi), .m_data(a_md));
  argmax_scheduler #(.NUM_CLASSES(26), .DATA_WIDTH(16)) u_b (
    .clk(clk), .resetn(resetn), .clear(clear), .s_valid(b_valid), .s_ready(b_ready),
    .s_data(b_data), .m_valid(b_mv), .m_ready(b_mr), .m_index(b_mi), .m_data(b_md));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (resetn && a_mv && a_mr) begin
      res_t e;
      if (qa.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_extra got idx=%0d data=%0h exp=none", a_mi, a_md);
      end else begin
        e = qa.pop_front();
        check("a_index", 32'(a_mi), 32'(e.i));
        check("a_data", 32'(a_md), 32'(e.d));
      end
    end

  always @(negedge clk)
    if (resetn && b_mv && b_mr) begin
      res_t e;
      if (qb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_extra got idx=%0d data=%0h exp=none", b_mi, b_md);
      end else begin
        e = qb.pop_front();
        check("b_index", 32'(b_mi), 32'(e.i));
        check("b_data", 32'(b_md), 32'(e.d));
      end
    end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic vec_t fill(input logic [15:0] x);
    vec_t v;
    for (int i = 0; i < 32; i++) v[i] = x;
    return v;
  endfunction

  task automatic send(input bit b, input vec_t v, input int n, input bit gaps, output int last);
    int t;
    bit rdy;
    last = 0;
    for (int c = 0; c < n; c++) begin
      if (gaps) begin
        if (b) b_valid = 0; else a_valid = 0;
        repeat ($urandom_range(0, 2)) tick();
      end
      if (b) begin b_valid = 1; b_data = v[c]; end
      else begin a_valid = 1; a_data = v[c]; end
      t = 0;
      do begin
        rdy = b ? b_ready : a_ready;
        last = cyc;
        tick();
        t++;
      end while (!rdy && t < 50);
      if (!rdy) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout got ready=0 exp ready=1");
      end
    end
    a_valid = 0;
    b_valid = 0;
  endtask

  task automatic wait_mv(input bit b, output int c);
    int t = 0;
    c = -1;
    do begin
      @(negedge clk);
      t++;
    end while (!(b ? b_mv : a_mv) && t < 40);
    if (b ? b_mv : a_mv) c = cyc;
    else begin
      n_tests++; n_fail++;
      $display("FAIL wait_m_valid got m_valid=0 exp m_valid=1");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int last, c;
    repeat (3) tick();
    resetn = 1;
    @(negedge clk);
    check("rst_s_ready", 32'(a_ready), 1);
    check("rst_m_valid", 32'(a_mv), 0);
    check("rst_m_index", 32'(a_mi), 0);
    check("rst_m_data", 32'(a_md), 0);

    // ascending ramp, full rate, latency from last handshake
    for (int i = 0; i < 32; i++) v[i] = 16'(i);
    qa.push_back('{5'd23, 16'd23});
    send(0, v, 24, 0, last);
    wait_mv(0, c);
    check("latency", 32'(c - last), 3);

    v = fill(16'hFF9C); v[5] = 16'hFFFF;
    qa.push_back('{5'd5, 16'hFFFF});
    send(0, v, 24, 0, last);
    wait_mv(0, c);

    v = fill(16'h0000); v[2] = 16'h7FFF; v[17] = 16'h7FFF;
    qa.push_back('{5'd2, 16'h7FFF});
    send(0, v, 24, 0, last);
    wait_mv(0, c);

    v = fill(16'h0000); v[1] = 16'd50; v[3] = 16'd50;
    qa.push_back('{5'd1, 16'd50});
    send(0, v, 24, 0, last);
    wait_mv(0, c);

    for (int i = 0; i < 32; i++) v[i] = 16'(i);
    v[9] = 16'd300;
    qa.push_back('{5'd9, 16'd300});
    send(0, v, 24, 1, last);
    wait_mv(0, c);

    // result backpressure
    for (int i = 0; i < 32; i++) v[i] = 16'(i);
    v[12] = 16'd1000;
    qa.push_back('{5'd12, 16'd1000});
    tick();
    a_mr = 0;
    send(0, v, 24, 0, last);
    wait_mv(0, c);
    for (int k = 0; k < 10; k++) begin
      check("hold_m_valid", 32'(a_mv), 1);
      check("hold_m_index", 32'(a_mi), 12);
      check("hold_m_data", 32'(a_md), 1000);
      check("hold_s_ready", 32'(a_ready), 0);
      @(negedge clk);
    end
    tick();
    a_mr = 1;

    // flush a partial frame, with a beat offered in the clear cycle
    send(0, fill(16'd500), 10, 0, last);
    a_valid = 1; a_data = 16'h7000; clear = 1;
    tick();
    clear = 0; a_valid = 0;
    v = fill(16'h0000); v[7] = 16'd9;
    qa.push_back('{5'd7, 16'd9});
    send(0, v, 24, 0, last);
    wait_mv(0, c);

    // 26 classes: padded final group
    qb.push_back('{5'd0, 16'h8000});
    send(1, fill(16'h8000), 26, 0, last);
    wait_mv(1, c);
    v = fill(16'hFFFF); v[25] = 16'd5;
    qb.push_back('{5'd25, 16'd5});
    send(1, v, 26, 0, last);
    wait_mv(1, c);

    // reset while holding a result
    tick();
    a_mr = 0;
    send(0, fill(16'd3), 24, 0, last);
    wait_mv(0, c);
    tick();
    resetn = 0;
    tick();
    resetn = 1;
    @(negedge clk);
    check("rsthold_m_valid", 32'(a_mv), 0);
    check("rsthold_m_index", 32'(a_mi), 0);
    check("rsthold_m_data", 32'(a_md), 0);
    check("rsthold_s_ready", 32'(a_ready), 1);
    tick();
    a_mr = 1;

    repeat (5) tick();
    check("a_queue_empty", 32'(qa.size()), 0);
    check("b_queue_empty", 32'(qb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
